// File: rtl/eth_tx_pkg.sv
// Shared constants and width helpers for the application-side transmit path.
package eth_tx_pkg;

  localparam int PKT_LEN_W_DEF = 16;
  localparam int UDP_CS_W_DEF  = 16;

  localparam int         ST_W    = 2;
  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  function automatic int keep_w_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int len_w_of(input int keep_w);
    return $clog2(keep_w + 1);
  endfunction

endpackage

// File: rtl/app_tx_buf.sv
// Single-packet word buffer: synchronous write, combinational read so data
// lines up with the registered read pointer in the same cycle.
module app_tx_buf #(
  parameter int  DATA_W = 16,
  parameter int  DEPTH  = 64,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/app_tx_streamer.sv
// Store-and-forward packet source: buffers one packet from the load side,
// then requests eth_tx and streams the words out, with abort/cancel support.
module app_tx_streamer
  import eth_tx_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int KEEP_W    = keep_w_of(DATA_W),
  parameter int LEN_W     = len_w_of(KEEP_W),
  parameter int PKT_LEN_W = PKT_LEN_W_DEF,
  parameter int UDP_CS_W  = UDP_CS_W_DEF,
  parameter int DEPTH     = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ld_valid_i,
  output logic                 ld_ready_o,
  input  logic [DATA_W-1:0]    ld_data_i,
  input  logic [LEN_W-1:0]     ld_len_i,
  input  logic                 ld_last_i,
  input  logic [UDP_CS_W-1:0]  ld_cs_i,
  input  logic                 abort_i,
  output logic                 app_early_v_o,
  input  logic                 app_ready_v_i,
  output logic                 app_valid_o,
  output logic                 app_last_o,
  output logic [DATA_W-1:0]    app_data_o,
  output logic [LEN_W-1:0]     app_len_o,
  output logic [PKT_LEN_W-1:0] app_pkt_len_o,
  output logic [UDP_CS_W-1:0]  app_cs_o,
  output logic                 app_cancel_o,
  output logic                 err_o,
  output logic [ST_W-1:0]      dbg_state
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(KEEP_W);

  logic [ST_W-1:0]      state;
  logic [AW-1:0]        wr_ptr, rd_ptr, last_idx;
  logic [PKT_LEN_W-1:0] byte_cnt, pkt_len;
  logic [UDP_CS_W-1:0]  cs_q;
  logic [LEN_W-1:0]     last_len;
  logic                 err_q;
  logic [DATA_W-1:0]    rd_data;
  logic                 ld_fire, bad_word, final_word, in_send;

  // Handshakes: a load word transfers on ld_valid_i & ld_ready_o at the clock
  // edge; an output word transfers whenever app_valid_o is high, which is
  // app_ready_v_i gated by SEND and suppressed in an abort cycle.
  assign ld_ready_o = (state == ST_LOAD) && !reset;
  assign ld_fire    = ld_valid_i && ld_ready_o;
  assign bad_word   = (ld_len_i == '0) || (ld_len_i > FULL_LEN) ||
                      (!ld_last_i && (ld_len_i != FULL_LEN)) ||
                      (!ld_last_i && (wr_ptr == '1));

  assign in_send       = (state == ST_SEND);
  assign final_word    = (rd_ptr == last_idx);
  assign app_early_v_o = (state == ST_REQ) || in_send;
  assign app_cancel_o  = in_send && abort_i;
  assign app_valid_o   = in_send && app_ready_v_i && !abort_i;
  assign app_last_o    = in_send && final_word;
  assign app_len_o     = !in_send ? '0 : (final_word ? last_len : FULL_LEN);
  assign app_pkt_len_o = (state == ST_LOAD) ? '0 : pkt_len;
  assign app_cs_o      = (state == ST_LOAD) ? '0 : cs_q;
  assign err_o         = err_q;
  assign dbg_state     = state;

  // Bytes beyond the word's valid length are forced to zero.
  always_comb begin
    app_data_o = '0;
    if (in_send) begin
      for (int i = 0; i < KEEP_W; i++) begin
        if (i < int'(app_len_o)) app_data_o[8*i +: 8] = rd_data[8*i +: 8];
      end
    end
  end

  app_tx_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .wr_en   (ld_fire && !abort_i && !bad_word),
    .wr_addr (wr_ptr),
    .wr_data (ld_data_i),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_LOAD;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_idx <= '0;
      byte_cnt <= '0;
      pkt_len  <= '0;
      cs_q     <= '0;
      last_len <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (abort_i) begin
            wr_ptr   <= '0;
            byte_cnt <= '0;
          end else if (ld_fire) begin
            if (bad_word) begin
              wr_ptr   <= '0;
              byte_cnt <= '0;
              err_q    <= 1'b1;
            end else if (ld_last_i) begin
              pkt_len  <= byte_cnt + PKT_LEN_W'(ld_len_i);
              cs_q     <= ld_cs_i;
              last_len <= ld_len_i;
              last_idx <= wr_ptr;
              wr_ptr   <= '0;
              byte_cnt <= '0;
              state    <= ST_REQ;
            end else begin
              wr_ptr   <= wr_ptr + 1'b1;
              byte_cnt <= byte_cnt + PKT_LEN_W'(ld_len_i);
            end
          end
        end
        ST_REQ: begin
          if (abort_i) begin
            state <= ST_LOAD;
          end else if (app_ready_v_i) begin
            state  <= ST_SEND;
            rd_ptr <= '0;
          end
        end
        ST_SEND: begin
          if (abort_i) begin
            state  <= ST_LOAD;
            rd_ptr <= '0;
          end else if (app_valid_o) begin
            if (final_word) begin
              state  <= ST_LOAD;
              rd_ptr <= '0;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_app_tx_streamer.sv
// Directed bench for app_tx_streamer with DATA_W=16 (two bytes per word).
module tb_app_tx_streamer;
  import eth_tx_pkg::*;

  localparam int DATA_W = 16;
  localparam int LEN_W  = 2;
  localparam int EXP_W  = 1 + LEN_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_valid_i, ld_ready_o, ld_last_i;
  logic [DATA_W-1:0] ld_data_i;
  logic [LEN_W-1:0]  ld_len_i;
  logic [15:0]       ld_cs_i;
  logic              abort_i;
  logic              app_early_v_o, app_ready_v_i, app_valid_o, app_last_o;
  logic [DATA_W-1:0] app_data_o;
  logic [LEN_W-1:0]  app_len_o;
  logic [15:0]       app_pkt_len_o, app_cs_o;
  logic              app_cancel_o, err_o;
  logic [1:0]        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  app_tx_streamer #(.DATA_W(16), .DEPTH(64)) dut (
    .clk(clk), .reset(reset),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_data_i(ld_data_i),
    .ld_len_i(ld_len_i), .ld_last_i(ld_last_i), .ld_cs_i(ld_cs_i),
    .abort_i(abort_i), .app_early_v_o(app_early_v_o), .app_ready_v_i(app_ready_v_i),
    .app_valid_o(app_valid_o), .app_last_o(app_last_o), .app_data_o(app_data_o),
    .app_len_o(app_len_o), .app_pkt_len_o(app_pkt_len_o), .app_cs_o(app_cs_o),
    .app_cancel_o(app_cancel_o), .err_o(err_o), .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads a packet of nbytes; byte k carries base+k. Expected words are queued
  // with unused bytes of a 1-byte final word shown as zero.
  task automatic load_pkt(input int nbytes, input logic [7:0] base, input logic [15:0] cs);
    int nw;
    logic lst;
    logic [LEN_W-1:0] ln;
    logic [7:0] b0, b1;
    nw = (nbytes + 1) / 2;
    for (int w = 0; w < nw; w++) begin
      lst = (w == nw - 1);
      ln  = lst ? LEN_W'(nbytes - 2 * w) : 2'd2;
      b0  = base + 8'(2 * w);
      b1  = base + 8'(2 * w + 1);
      ld_valid_i = 1'b1;
      ld_data_i  = {b1, b0};
      ld_len_i   = ln;
      ld_last_i  = lst;
      ld_cs_i    = lst ? cs : 16'h1234;
      exp_q.push_back({lst, ln, (ln == 2'd1) ? {8'h00, b0} : {b1, b0}});
      tick();
    end
    ld_valid_i = 1'b0;
    ld_last_i  = 1'b0;
  endtask

  // Called the cycle after the last load word. Ready is low for `pre` cycles,
  // then high except for stall_n cycles starting at cycle stall_at.
  task automatic send_pkt(input logic [15:0] plen, input logic [15:0] cs,
                          input int pre, input int stall_at, input int stall_n);
    int c, first;
    bit in_send, done;
    logic [EXP_W-1:0] e;
    c = 0; first = -1; in_send = 0; done = 0;
    total++;
    if (app_early_v_o !== 1'b1) begin
      bad++; $display("FAIL early_v_latency got=%b want=1", app_early_v_o);
    end
    total++;
    if (app_pkt_len_o !== plen) begin
      bad++; $display("FAIL pkt_len got=%0d want=%0d", app_pkt_len_o, plen);
    end
    total++;
    if (app_cs_o !== cs) begin
      bad++; $display("FAIL cs got=%h want=%h", app_cs_o, cs);
    end
    while (!done && c < 80) begin
      app_ready_v_i = (c >= pre) && !(c >= stall_at && c < stall_at + stall_n);
      #1;
      total++;
      if (app_valid_o !== (in_send && app_ready_v_i)) begin
        bad++; $display("FAIL valid_gate cyc=%0d got=%b want=%b", c, app_valid_o, in_send && app_ready_v_i);
      end
      total++;
      if (app_early_v_o !== 1'b1 || app_pkt_len_o !== plen) begin
        bad++; $display("FAIL req_hold cyc=%0d early=%b len=%0d want len=%0d", c, app_early_v_o, app_pkt_len_o, plen);
      end
      if (app_valid_o === 1'b1) begin
        if (first < 0) first = c;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL extra_word cyc=%0d data=%h", c, app_data_o);
        end else begin
          e = exp_q.pop_front();
          if ({app_last_o, app_len_o, app_data_o} !== e) begin
            bad++; $display("FAIL word cyc=%0d got=%h want=%h", c, {app_last_o, app_len_o, app_data_o}, e);
          end
          done = e[EXP_W-1];
        end
      end
      if (!in_send && app_ready_v_i) in_send = 1;
      @(posedge clk);
      #1;
      c++;
    end
    app_ready_v_i = 1'b0;
    total++;
    if (!done) begin
      bad++; $display("FAIL send_timeout got=%0d cycles want=final word", c);
    end
    total++;
    if (first != pre + 1) begin
      bad++; $display("FAIL first_valid_latency got=%0d want=%0d", first, pre + 1);
    end
    total++;
    if (ld_ready_o !== 1'b1 || app_early_v_o !== 1'b0 || dbg_state !== ST_LOAD) begin
      bad++; $display("FAIL return_to_load ready=%b early=%b state=%0d want 1/0/0", ld_ready_o, app_early_v_o, dbg_state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ld_valid_i = 1'b0; ld_data_i = '0; ld_len_i = '0; ld_last_i = 1'b0;
    ld_cs_i = '0; abort_i = 1'b0; app_ready_v_i = 1'b0;
    repeat (3) tick();
    total++;
    if (ld_ready_o !== 1'b0) begin
      bad++; $display("FAIL reset_ld_ready got=%b want=0", ld_ready_o);
    end
    total++;
    if ({app_early_v_o, app_valid_o, app_last_o, app_cancel_o, err_o} !== 5'b0 ||
        app_data_o !== '0 || app_len_o !== '0 || app_pkt_len_o !== '0 || app_cs_o !== '0) begin
      bad++; $display("FAIL reset_outputs got early=%b valid=%b data=%h plen=%0d cs=%h want all 0",
                      app_early_v_o, app_valid_o, app_data_o, app_pkt_len_o, app_cs_o);
    end
    reset = 1'b0;
    #1;
    total++;
    if (ld_ready_o !== 1'b1 || dbg_state !== ST_LOAD) begin
      bad++; $display("FAIL post_reset_load ready=%b state=%0d want 1/0", ld_ready_o, dbg_state);
    end
    tick();
  endtask

  task automatic test_19_byte();
    load_pkt(19, 8'h10, 16'hBEEF);
    send_pkt(16'd19, 16'hBEEF, 0, 100, 0);
  endtask

  task automatic test_delayed_ready();
    load_pkt(20, 8'h40, 16'h5A5A);
    send_pkt(16'd20, 16'h5A5A, 5, 10, 2);
  endtask

  task automatic test_abort();
    logic [EXP_W-1:0] e;
    // abort in SEND on the third word
    load_pkt(20, 8'h80, 16'h1111);
    app_ready_v_i = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      e = exp_q.pop_front();
      if (app_valid_o !== 1'b1 || {app_last_o, app_len_o, app_data_o} !== e) begin
        bad++; $display("FAIL abort_pre_word k=%0d valid=%b got=%h want=%h", k, app_valid_o,
                        {app_last_o, app_len_o, app_data_o}, e);
      end
      tick();
    end
    abort_i = 1'b1;
    #1;
    total++;
    if (app_cancel_o !== 1'b1 || app_valid_o !== 1'b0) begin
      bad++; $display("FAIL abort_send cancel=%b valid=%b want 1/0", app_cancel_o, app_valid_o);
    end
    tick();
    abort_i = 1'b0; app_ready_v_i = 1'b0;
    #1;
    total++;
    if (app_cancel_o !== 1'b0 || ld_ready_o !== 1'b1 || dbg_state !== ST_LOAD) begin
      bad++; $display("FAIL abort_recover cancel=%b ready=%b state=%0d want 0/1/0", app_cancel_o, ld_ready_o, dbg_state);
    end
    exp_q.delete();
    load_pkt(4, 8'hC0, 16'h0004);
    send_pkt(16'd4, 16'h0004, 0, 100, 0);
    // abort in REQ
    load_pkt(2, 8'hD0, 16'h2222);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    total++;
    if (app_early_v_o !== 1'b0 || ld_ready_o !== 1'b1) begin
      bad++; $display("FAIL abort_req early=%b ready=%b want 0/1", app_early_v_o, ld_ready_o);
    end
    exp_q.delete();
    // abort in LOAD discards the partial word count
    ld_valid_i = 1'b1; ld_data_i = 16'hFFFF; ld_len_i = 2'd2; ld_last_i = 1'b0;
    tick();
    ld_valid_i = 1'b0; abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL abort_load_err got=%b want=0", err_o);
    end
    load_pkt(2, 8'hE0, 16'h3333);
    send_pkt(16'd2, 16'h3333, 0, 100, 0);
  endtask

  task automatic test_malformed();
    ld_valid_i = 1'b1; ld_data_i = 16'hAAAA; ld_len_i = 2'd1; ld_last_i = 1'b0;
    tick();
    ld_valid_i = 1'b0;
    total++;
    if (err_o !== 1'b1 || app_early_v_o !== 1'b0 || dbg_state !== ST_LOAD) begin
      bad++; $display("FAIL short_nonlast err=%b early=%b state=%0d want 1/0/0", err_o, app_early_v_o, dbg_state);
    end
    tick();
    total++;
    if (err_o !== 1'b0 || ld_ready_o !== 1'b1) begin
      bad++; $display("FAIL err_pulse_width err=%b ready=%b want 0/1", err_o, ld_ready_o);
    end
    for (int i = 0; i < 64; i++) begin
      ld_valid_i = 1'b1; ld_data_i = 16'(i); ld_len_i = 2'd2; ld_last_i = 1'b0;
      tick();
      if (i == 62) begin
        total++;
        if (err_o !== 1'b0) begin
          bad++; $display("FAIL overflow_early got=%b want=0 after 63 words", err_o);
        end
      end
    end
    ld_valid_i = 1'b0;
    total++;
    if (err_o !== 1'b1 || app_early_v_o !== 1'b0 || dbg_state !== ST_LOAD) begin
      bad++; $display("FAIL overflow err=%b early=%b state=%0d want 1/0/0", err_o, app_early_v_o, dbg_state);
    end
    tick();
    load_pkt(3, 8'h20, 16'hCAFE);
    send_pkt(16'd3, 16'hCAFE, 0, 100, 0);
  endtask

  task automatic test_reset_in_send();
    logic [EXP_W-1:0] e;
    load_pkt(6, 8'h60, 16'h6666);
    app_ready_v_i = 1'b1;
    tick();
    e = exp_q.pop_front();
    total++;
    if (app_valid_o !== 1'b1 || {app_last_o, app_len_o, app_data_o} !== e) begin
      bad++; $display("FAIL rst_pre_word valid=%b got=%h want=%h", app_valid_o, {app_last_o, app_len_o, app_data_o}, e);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; app_ready_v_i = 1'b0;
    #1;
    total++;
    if ({app_early_v_o, app_valid_o, app_last_o, app_cancel_o, err_o} !== 5'b0 ||
        app_data_o !== '0 || app_len_o !== '0 || app_pkt_len_o !== '0 || app_cs_o !== '0 ||
        dbg_state !== ST_LOAD || ld_ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_in_send early=%b valid=%b plen=%0d state=%0d ready=%b want 0/0/0/0/1",
                      app_early_v_o, app_valid_o, app_pkt_len_o, dbg_state, ld_ready_o);
    end
    exp_q.delete();
    tick();
    load_pkt(5, 8'h70, 16'h7777);
    send_pkt(16'd5, 16'h7777, 0, 100, 0);
  endtask

  task automatic test_back_to_back();
    load_pkt(1, 8'h91, 16'h0001);
    send_pkt(16'd1, 16'h0001, 0, 100, 0);
    load_pkt(1, 8'hA2, 16'h0002);
    send_pkt(16'd1, 16'h0002, 0, 100, 0);
  endtask

  initial begin
    test_reset();
    test_19_byte();
    test_delayed_ready();
    test_abort();
    test_malformed();
    test_reset_in_send();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover_words got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
